// File: rtl/cache_fill_if.sv
// Miss/fill handshake between the cache, the fill FSM and the memory port.
`timescale 1ns/1ps
interface cache_fill_if;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        fsm_busy;
   logic        memory_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [15:0] data_array_address;
   logic        write_tag_array;

   // Fill FSM side: issues memory reads and cache array writes.
   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, memory_read, memory_address,
             write_data_array, data_array_address, write_tag_array
   );

   // Cache/memory side: reports misses and returns read data.
   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, memory_read, memory_address,
             write_data_array, data_array_address, write_tag_array
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues WORDS consecutive word reads
// and writes each returned word into the data array, tagging on the last one.
`timescale 1ns/1ps
module cache_fill_fsm #(
   parameter int unsigned WORDS = 8
) (
   input logic          clk,
   input logic          rst,
   cache_fill_if.master bus
);
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CNT_W  = $clog2(WORDS + 1);
   localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;
   logic [CNT_W-1:0]    issue_idx;
   logic                issuing;
   logic                receiving;

   // State, latched block base and request/receive counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
      end
   end

   // Next-state and output decode; array writes follow memory_data_valid directly.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      issuing     = 1'b0;
      receiving   = 1'b0;
      bus.write_tag_array = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.miss_detected) begin
               base_d      = bus.miss_address & BLOCK_MASK;
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            issuing = (issue_cnt_q < CNT_FULL);
            if (issuing) begin
               issue_cnt_d = issue_cnt_q + CNT_ONE;
            end
            receiving = bus.memory_data_valid && (recv_cnt_q < CNT_FULL);
            if (receiving) begin
               recv_cnt_d = recv_cnt_q + CNT_ONE;
               if (recv_cnt_q == CNT_LAST) begin
                  bus.write_tag_array = 1'b1;
                  state_d             = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Once all requests are out, keep presenting the last request address.
      issue_idx = (issue_cnt_q == CNT_FULL) ? CNT_LAST : issue_cnt_q;

      bus.fsm_busy           = (state_q == WAIT);
      bus.memory_read        = issuing;
      bus.memory_address     = base_q + (ADDR_W'(issue_idx) << 1);
      bus.write_data_array   = receiving;
      bus.data_array_address = receiving ? (base_q + (ADDR_W'(recv_cnt_q) << 1)) : '0;
   end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a fixed-latency memory model.
`timescale 1ns/1ps
module tb_cache_fill_fsm;
   localparam int unsigned WORDS   = 8;
   localparam int unsigned MEM_LAT = 4;
   localparam int          TIMEOUT = 200;

   logic clk = 1'b0;
   logic rst;

   cache_fill_if bus ();

   cache_fill_fsm #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Scoreboard queues filled by stimulus, drained by the monitor.
   logic [15:0] exp_req_q[$];
   logic [16:0] exp_wr_q[$];   // {tag, address}
   int          exp_busy_q[$];
   int          flush_gen = 0;

   // Monitor-owned state.
   int          busy_len = 0;
   int          wr_seen  = 0;
   int          seen_gen = 0;
   logic [15:0] last_req = 16'h0000;

   // Memory model control.
   bit gap_mode = 1'b0;
   bit inject   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},       32'(bus.fsm_busy),           32'h0);
      check({tag, "_mem_read"},   32'(bus.memory_read),        32'h0);
      check({tag, "_mem_addr"},   32'(bus.memory_address),     32'h0);
      check({tag, "_wr_data"},    32'(bus.write_data_array),   32'h0);
      check({tag, "_array_addr"}, 32'(bus.data_array_address), 32'h0);
      check({tag, "_wr_tag"},     32'(bus.write_tag_array),    32'h0);
   endtask

   // Memory: each read returns MEM_LAT cycles later; gap mode spaces returns 1,0,0,1,...
   initial begin : memory_model
      logic [15:0] addr_q[$];
      int          rdy_q[$];
      int          cyc;
      int          gap_ctr;
      bit          ready;
      cyc     = 0;
      gap_ctr = 0;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0000;
      forever begin
         @(negedge clk);
         if (bus.memory_read) begin
            addr_q.push_back(bus.memory_address);
            rdy_q.push_back(cyc + int'(MEM_LAT));
         end
         @(posedge clk);
         cyc++;
         #1;
         if (!gap_mode) gap_ctr = 0;
         ready = (rdy_q.size() != 0) && (rdy_q[0] <= cyc);
         if (ready && gap_ctr == 0) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = addr_q.pop_front() ^ 16'hA5A5;
            void'(rdy_q.pop_front());
            if (gap_mode) gap_ctr = 1;
         end else begin
            bus.memory_data_valid = inject;
            bus.memory_data       = 16'hDEAD;
            if (ready && gap_ctr != 0) gap_ctr = (gap_ctr == 2) ? 0 : gap_ctr + 1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a request, write or end of busy.
   always @(negedge clk) begin
      if (seen_gen != flush_gen) begin
         seen_gen = flush_gen;
         busy_len = 0;
      end
      if (bus.memory_read) begin
         checks++;
         if (exp_req_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: addr %h, none required", bus.memory_address);
         end else begin
            checks--;
            check("req_addr", 32'(bus.memory_address), 32'(exp_req_q.pop_front()));
         end
         last_req = bus.memory_address;
      end else if (bus.fsm_busy) begin
         check("req_addr_hold", 32'(bus.memory_address), 32'(last_req));
      end

      if (bus.write_data_array) begin
         wr_seen++;
         checks++;
         if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %h data %h tag %b, none required",
                     bus.data_array_address, bus.memory_data, bus.write_tag_array);
         end else begin
            logic [16:0] e;
            checks--;
            e = exp_wr_q.pop_front();
            check("wr_addr", 32'(bus.data_array_address), 32'(e[15:0]));
            check("wr_tag",  32'(bus.write_tag_array),    32'(e[16]));
         end
      end else if (bus.write_tag_array) begin
         check("tag_without_write", 32'(bus.write_tag_array), 32'h0);
      end

      if (bus.fsm_busy) begin
         busy_len++;
      end else if (busy_len != 0) begin
         checks++;
         if (exp_busy_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy: %0d busy cycles, no fill required", busy_len);
         end else begin
            checks--;
            check("busy_cycles", 32'(busy_len), 32'(exp_busy_q.pop_front()));
         end
         busy_len = 0;
      end
   end

   task automatic expect_fill(input logic [15:0] base, input int busy);
      for (int i = 0; i < int'(WORDS); i++) begin
         exp_req_q.push_back(base + 16'(2 * i));
         exp_wr_q.push_back({(i == int'(WORDS) - 1), base + 16'(2 * i)});
      end
      exp_busy_q.push_back(busy);
   endtask

   task automatic issue_miss(input logic [15:0] addr);
      @(posedge clk); #1;
      bus.miss_detected = 1'b1;
      bus.miss_address  = addr;
      @(posedge clk); #1;
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'h5A5A;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.fsm_busy && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (bus.fsm_busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: still busy after %0d cycles", name, TIMEOUT);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      int wr_start;
      rst = 1'b1;
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'h0000;
      #1;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Valid in IDLE: no write, and the next fill still starts at word 0.
      @(posedge clk); #1 inject = 1'b1;
      @(negedge clk);
      check("idle_valid_no_write", 32'(bus.write_data_array), 32'h0);
      @(posedge clk); #1 inject = 1'b0;

      // Basic fill, unaligned miss.
      expect_fill(16'h1230, 12);
      issue_miss(16'h1236);
      wait_idle("fill_1236");

      // Top of address space, no wrap.
      expect_fill(16'hFFF0, 12);
      issue_miss(16'hFFFF);
      wait_idle("fill_ffff");
      check("last_req_ffff", 32'(last_req), 32'h0000_FFFE);

      // Gapped valid stream: data in busy cycles 5, 8, ..., 26.
      gap_mode = 1'b1;
      expect_fill(16'h0040, 26);
      issue_miss(16'h0040);
      wait_idle("fill_gap");
      gap_mode = 1'b0;

      // Second miss during a fill is ignored.
      expect_fill(16'h1000, 12);
      issue_miss(16'h1000);
      repeat (3) @(posedge clk);
      #1;
      bus.miss_detected = 1'b1;
      bus.miss_address  = 16'h2000;
      @(posedge clk); #1;
      bus.miss_detected = 1'b0;
      wait_idle("fill_1000");

      // Miss in the completing cycle does not start a fill.
      expect_fill(16'h3000, 12);
      issue_miss(16'h3008);
      repeat (11) @(posedge clk);
      #1;
      bus.miss_detected = 1'b1;
      bus.miss_address  = 16'h4000;
      @(negedge clk);
      check("tag_on_last_cycle", 32'(bus.write_tag_array), 32'h1);
      @(posedge clk); #1;
      bus.miss_detected = 1'b0;
      @(negedge clk);
      check("no_restart_on_drop", 32'(bus.fsm_busy), 32'h0);
      wait_idle("fill_3000");

      // Reset after three data words abandons the fill.
      expect_fill(16'h0080, 12);
      wr_start = wr_seen;
      issue_miss(16'h0080);
      n = 0;
      while (wr_seen - wr_start < 3 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("reset_fill_reached_3_words", 32'(wr_seen - wr_start), 32'd3);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      exp_req_q.delete();
      exp_wr_q.delete();
      exp_busy_q.delete();
      flush_gen++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("idle_after_reset", 32'(bus.fsm_busy), 32'h0);

      // Clean fill after the abandoned one.
      expect_fill(16'h00A0, 12);
      issue_miss(16'h00A0);
      wait_idle("fill_00a0");

      check("req_queue_drained",  32'(exp_req_q.size()),  32'h0);
      check("wr_queue_drained",   32'(exp_wr_q.size()),   32'h0);
      check("busy_queue_drained", 32'(exp_busy_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have parameter WORDS, default 8: 16-bit words per cache block (16-byte block).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port miss_detected, input, 1: the cache reports a miss this cycle.
REQ-005 The block SHALL have port miss_address, input, 16: the byte address that missed.
REQ-006 The block SHALL have port memory_data, input, 16: read data returned by the multi-cycle memory.
REQ-007 The block SHALL have port memory_data_valid, input, 1: memory_data holds a returned word this cycle.
REQ-008 The block SHALL have port fsm_busy, output, 1: a fill is in progress; the pipeline stalls fetch or memory access.
REQ-009 The block SHALL have port memory_read, output, 1: memory_address is a valid read request this cycle.
REQ-010 The block SHALL have port memory_address, output, 16: word address issued to memory.
REQ-011 The block SHALL have port write_data_array, output, 1: write memory_data into the cache data array this cycle.
REQ-012 The block SHALL have port data_array_address, output, 16: cache word address for write_data_array.
REQ-013 The block SHALL have port write_tag_array, output, 1: write the tag and set the valid bit for the filled block this cycle.

Function
REQ-014 The FSM SHALL have two states, IDLE and WAIT, and SHALL use two counters: issue_cnt and recv_cnt, each 0..WORDS.
REQ-015 In IDLE, when miss_detected=1 at a clock edge:
- latch base = miss_address & 0xFFF0;
- clear both counters;
- enter WAIT.
REQ-016 miss_detected SHALL be ignored in WAIT.
REQ-017 Changes on miss_address after the latching edge SHALL have no effect.
REQ-018 fsm_busy SHALL be 1 exactly while the state is WAIT.
REQ-019 In WAIT, while issue_cnt < WORDS:
- memory_read=1;
- memory_address = base + 2*issue_cnt;
- issue_cnt increments at each edge.
This gives one request per cycle and WORDS consecutive requests.
REQ-020 When issue_cnt = WORDS:
- memory_read=0;
- memory_address SHALL hold its last value.
REQ-021 In WAIT, when memory_data_valid=1:
- write_data_array=1;
- data_array_address = base + 2*recv_cnt;
- recv_cnt increments at the edge.
REQ-022 In WAIT, write_data_array SHALL be 0 whenever memory_data_valid=0; the block SHALL tolerate gaps of any length in the valid stream.
REQ-023 When memory_data_valid=1 and recv_cnt = WORDS-1:
- write_tag_array SHALL be 1 in that same cycle;
- the state SHALL return to IDLE at that edge.
REQ-024 write_tag_array SHALL be 1 for exactly one cycle per fill.
REQ-025 memory_data_valid in IDLE SHALL be ignored: no array write and no counter change.
REQ-026 Address arithmetic SHALL be 16-bit. For base 0xFFF0 the last word address is 0xFFFE; no carry out of the block.
REQ-027 Odd miss_address values SHALL be aligned down by the 0xFFF0 mask with no error.
REQ-028 A miss_detected arriving in the same cycle the FSM returns to IDLE SHALL NOT start a fill. A new fill starts only on a miss sampled while in IDLE, so the earliest restart is one cycle after completion.
REQ-029 Minimum fill latency with a 4-cycle memory SHALL be:
- busy from the edge after the miss;
- requests in busy cycles 1-8;
- data in busy cycles 5-12;
- IDLE after busy cycle 12.
That is 12 busy cycles.
REQ-030 All outputs SHALL be registered state or decoded from state and counters only, except write_data_array, data_array_address and write_tag_array, which also depend on memory_data_valid in the same cycle.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, force:
- state IDLE;
- base, issue_cnt and recv_cnt to 0;
- fsm_busy, memory_read, write_data_array and write_tag_array to 0;
- memory_address and data_array_address to 0x0000.
REQ-032 Reset asserted mid-fill SHALL abandon the fill with no tag write; memory_data_valid pulses still arriving after reset release SHALL be ignored.

Verification
REQ-033 Miss at 0x1236, 4-cycle memory:
- requests 0x1230, 0x1232, …, 0x123E in consecutive cycles;
- 8 data writes to 0x1230..0x123E;
- write_tag_array only with the 8th word;
- fsm_busy high for 12 cycles.
REQ-034 Miss at 0xFFFF:
- base 0xFFF0;
- last request and last data write at 0xFFFE;
- no wrap to 0x0000.
REQ-035 Valid stream with gaps (pattern 1,0,0,1,…) after miss at 0x0040:
- data_array_address advances only on valid;
- fill completes after the 8th valid;
- no extra writes.
REQ-036 Second miss_detected pulse at 0x2000 during a fill at 0x1000:
- ignored; all addresses stay 0x1000-based.
REQ-037 Miss on the cycle busy drops:
- no new fill that cycle.
REQ-038 rst pulsed after 3 data words of a fill at 0x0080:
- outputs 0 asynchronously; no tag write;
- a later miss at 0x00A0 performs a clean fill starting at 0x00A0.
